// File: rtl/filter_pkg.sv
// Shared types and defaults for the filter_inverse receive path.
package filter_pkg;

  localparam int unsigned W_DEFAULT = 16;

  typedef logic [W_DEFAULT-1:0] sample_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/stream_reg.sv
// One-entry valid/ready output register; in_ready is combinational so a full
// entry can be replaced in the same cycle it is consumed.
module stream_reg
  import filter_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  state_e       state_q;
  logic [W-1:0] data_q;
  logic         accept;
  logic         consume;

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  // clear wins over a same-cycle accept; the dropped sample never reaches the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else if (clear) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q <= FULL;
            data_q  <= in_data;
          end
        end
        FULL: begin
          if (accept) begin
            data_q <= in_data;
          end else if (consume) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/filter_inverse.sv
// Inverse of Y[n] = X[n] + X[n-1] + Y[n-1] (mod 2^W) with valid/ready on both sides.
// Optional accepted-sample counter enabled by FILTER_INV_STATS_EN.
module filter_inverse
  import filter_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
`ifdef FILTER_INV_STATS_EN
  ,
  output logic [31:0]  sample_cnt
`endif
);

  logic [W-1:0] yn_1_q;
  logic [W-1:0] xn_1_q;
  logic [W-1:0] x;
  logic         accept;

  assign x      = in_data - yn_1_q - xn_1_q;
  assign accept = in_valid && in_ready && !clear;

  stream_reg #(
    .W(W)
  ) u_stream_reg (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      yn_1_q <= '0;
      xn_1_q <= '0;
    end else if (clear) begin
      yn_1_q <= '0;
      xn_1_q <= '0;
    end else if (accept) begin
      yn_1_q <= in_data;
      xn_1_q <= x;
    end
  end

`ifdef FILTER_INV_STATS_EN
  logic [31:0] cnt_q;

  assign sample_cnt = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_filter_inverse.sv
// Directed bench for filter_inverse, closing the loop with a forward filter model.
module tb_filter_inverse;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
`ifdef FILTER_INV_STATS_EN
  logic [31:0] sample_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  filter_inverse #(
    .W(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef FILTER_INV_STATS_EN
    ,
    .sample_cnt(sample_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
  endtask

  logic [15:0] fx_prev;
  logic [15:0] fy_prev;
  logic [15:0] xr;
  logic [15:0] yr;

  initial begin
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #12;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data", {16'd0, out_data}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    step();

    // 1: back-to-back 1, 4, 9 -> 1, 2, 3
    in_valid = 1'b1;
    in_data  = 16'd1;
    step();
    check("t1_valid0", {31'd0, out_valid}, 32'd1);
    check("t1_x0", {16'd0, out_data}, 32'd1);
    in_data = 16'd4;
    step();
    check("t1_x1", {16'd0, out_data}, 32'd2);
    in_data = 16'd9;
    step();
    check("t1_x2", {16'd0, out_data}, 32'd3);
    in_valid = 1'b0;
    step();
    check("t1_drain", {31'd0, out_valid}, 32'd0);

    // 2: wraparound
    do_clear();
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    step();
    check("t2_x0", {16'd0, out_data}, 32'h0000FFFF);
    in_data = 16'h0000;
    step();
    check("t2_x1", {16'd0, out_data}, 32'h00000002);

    // 3: backpressure
    do_clear();
    in_valid = 1'b1;
    in_data  = 16'd1;
    step();
    check("t3_x0", {16'd0, out_data}, 32'd1);
    out_ready = 1'b0;
    in_data   = 16'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_in_ready_stall", {31'd0, in_ready}, 32'd0);
      step();
      check("t3_hold_data", {16'd0, out_data}, 32'd1);
      check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("t3_in_ready_release", {31'd0, in_ready}, 32'd1);
    step();
    check("t3_x1", {16'd0, out_data}, 32'd2);
    in_data = 16'd9;
    step();
    check("t3_x2", {16'd0, out_data}, 32'd3);
    in_valid = 1'b0;
    step();
    check("t3_drain", {31'd0, out_valid}, 32'd0);

    // 4: clear between Y=4 and Y=9
    do_clear();
    in_valid = 1'b1;
    in_data  = 16'd4;
    step();
    check("t4_x0", {16'd0, out_data}, 32'd4);
    out_ready = 1'b0;
    do_clear();
    check("t4_valid_after_clear", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'd9;
    step();
    check("t4_x1", {16'd0, out_data}, 32'd9);
    in_valid = 1'b0;
    step();

    // 5: async reset mid-stream, then closed loop
    in_valid  = 1'b1;
    in_data   = 16'd7;
    out_ready = 1'b0;
    step();
    check("t5_pending", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_valid", {31'd0, out_valid}, 32'd0);
    check("t5_async_data", {16'd0, out_data}, 32'd0);
    #2;
    reset     = 1'b0;
    out_ready = 1'b1;
    step();
    in_valid = 1'b1;
    in_data  = 16'd5;
    step();
    check("t5_after_reset", {16'd0, out_data}, 32'd5);
    do_clear();
    fx_prev  = '0;
    fy_prev  = '0;
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      xr      = 16'($urandom);
      yr      = xr + fx_prev + fy_prev;
      fx_prev = xr;
      fy_prev = yr;
      in_data = yr;
      step();
      check("t5_loop", {16'd0, out_data}, {16'd0, xr});
    end
    in_valid = 1'b0;
    step();

`ifdef FILTER_INV_STATS_EN
    // 6: counter with two stalled cycles
    do_clear();
    check("t6_cnt_zero", sample_cnt, 32'd0);
    in_valid = 1'b1;
    in_data  = 16'd3;
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b0;
    step();
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    in_valid = 1'b0;
    check("t6_cnt_seven", sample_cnt, 32'd7);
    do_clear();
    check("t6_cnt_cleared", sample_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
